lsu_mem_ctrl: RTL and testbench

- Sequences lw/sw requests from the core onto the single-port synchronous data memory (256 x 32-bit words, word-addressed).
- Computes effective address = base + sign-extended 16-bit offset, range-checks it and drives one memory access per request.
- Returns load data and the destination register index to write-back over a valid/ready response channel.
- Sits between decode/execute and the data memory; it is the only master on the memory port.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_ea_calc.sv | 19 +
 rtl/lsu_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, widths and helpers for the load/store unit memory controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam int OFF_W     = 16;
  localparam int REG_IDX_W = 5;
  localparam int BASE_W    = 32;

  function automatic logic signed [BASE_W-1:0] sext_off(input logic signed [OFF_W-1:0] off);
    return {{(BASE_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/lsu_ea_calc.sv
// Effective-address adder: base + sign-extended offset, plus word-range check.
module lsu_ea_calc
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [BASE_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  output logic [BASE_W-1:0] ea,
  output logic              in_range
);

  always_comb begin
    // Two's-complement add wraps modulo 2^32, which is the intended behaviour.
    ea       = base + sext_off(offset);
    in_range = (ea[BASE_W-1:ADDR_W] == '0);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequences one lw/sw at a time onto a single-port synchronous data memory.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BASE_W-1:0]    req_base,
  input  logic [OFF_W-1:0]     req_offset,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [REG_IDX_W-1:0] req_rd,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_we,
  output logic [REG_IDX_W-1:0] rsp_rd,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int CNT_W = 2;

  lsu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;

  logic [BASE_W-1:0]    ea;
  logic                 ea_in_range;
  logic                 accept;
  logic                 unused_ea_hi;

  lsu_ea_calc #(.ADDR_W(ADDR_W)) u_ea_calc (
    .base     (req_base),
    .offset   (req_offset),
    .ea       (ea),
    .in_range (ea_in_range)
  );

  // Upper EA bits only matter for the range check done inside the adder.
  assign unused_ea_hi = ^ea[BASE_W-1:ADDR_W];
  assign accept       = req_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ea_in_range ? ISSUE : RESP;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mem_en    = (state_q == ISSUE);
    mem_we    = (state_q == ISSUE) && we_q;
    rsp_valid = (state_q == RESP);
  end

  // Address/write data update only when a real access is coming, so the memory
  // port holds its last values between strobes.
  always_comb begin
    cnt_d      = cnt_q;
    we_d       = we_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    if (accept) begin
      we_d       = req_we;
      rd_d       = req_rd;
      err_d      = !ea_in_range;
      rsp_data_d = '0;
      if (ea_in_range) begin
        addr_d  = ea[ADDR_W-1:0];
        wdata_d = req_wdata;
      end
    end
    if (state_q == ISSUE) cnt_d = CNT_W'(MEM_LAT - 1);
    if (state_q == WAIT) begin
      if (cnt_q == '0) rsp_data_d = mem_rdata;
      else             cnt_d      = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_we    = we_q;
  assign rsp_rd    = rd_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst1_n, rst3_n, sel3;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_base, req_wdata;
  logic [15:0] req_offset;
  logic [4:0]  req_rd;

  logic        d1_req_ready, d1_mem_en, d1_mem_we, d1_rsp_valid, d1_rsp_we, d1_rsp_err, d1_busy;
  logic [7:0]  d1_mem_addr;
  logic [31:0] d1_mem_wdata, d1_mem_rdata, d1_rsp_data;
  logic [4:0]  d1_rsp_rd;
  logic        d3_req_ready, d3_mem_en, d3_mem_we, d3_rsp_valid, d3_rsp_we, d3_rsp_err, d3_busy;
  logic [7:0]  d3_mem_addr;
  logic [31:0] d3_mem_wdata, d3_mem_rdata, d3_rsp_data;
  logic [4:0]  d3_rsp_rd;

  logic        o_req_ready, o_mem_en, o_mem_we, o_rsp_valid, o_rsp_we, o_rsp_err, o_busy;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_wdata, o_rsp_data;
  logic [4:0]  o_rsp_rd;

  logic        pl_we, pl_sel;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  int n_checks = 0;
  int n_fail   = 0;
  int en1_cnt  = 0;
  int acc1_cnt = 0;
  int we_viol  = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(req_valid), .req_ready(d1_req_ready),
    .req_we(req_we), .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata), .rsp_valid(d1_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_we(d1_rsp_we), .rsp_rd(d1_rsp_rd), .rsp_data(d1_rsp_data),
    .rsp_err(d1_rsp_err), .busy(d1_busy)
  );

  lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid), .req_ready(d3_req_ready),
    .req_we(req_we), .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
    .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata), .rsp_valid(d3_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_we(d3_rsp_we), .rsp_rd(d3_rsp_rd), .rsp_data(d3_rsp_data),
    .rsp_err(d3_rsp_err), .busy(d3_busy)
  );

  assign o_req_ready = sel3 ? d3_req_ready : d1_req_ready;
  assign o_mem_en    = sel3 ? d3_mem_en    : d1_mem_en;
  assign o_mem_we    = sel3 ? d3_mem_we    : d1_mem_we;
  assign o_mem_addr  = sel3 ? d3_mem_addr  : d1_mem_addr;
  assign o_mem_wdata = sel3 ? d3_mem_wdata : d1_mem_wdata;
  assign o_rsp_valid = sel3 ? d3_rsp_valid : d1_rsp_valid;
  assign o_rsp_we    = sel3 ? d3_rsp_we    : d1_rsp_we;
  assign o_rsp_rd    = sel3 ? d3_rsp_rd    : d1_rsp_rd;
  assign o_rsp_data  = sel3 ? d3_rsp_data  : d1_rsp_data;
  assign o_rsp_err   = sel3 ? d3_rsp_err   : d1_rsp_err;
  assign o_busy      = sel3 ? d3_busy      : d1_busy;

  // Memory models: read data is only valid exactly MEM_LAT cycles after the strobe.
  always @(posedge clk) begin
    if (pl_we && !pl_sel)          mem1[pl_addr]     <= pl_data;
    else if (d1_mem_en && d1_mem_we) mem1[d1_mem_addr] <= d1_mem_wdata;
    if (pl_we && pl_sel)           mem3[pl_addr]     <= pl_data;
    else if (d3_mem_en && d3_mem_we) mem3[d3_mem_addr] <= d3_mem_wdata;
    pipe1    <= (d1_mem_en && !d1_mem_we) ? mem1[d1_mem_addr] : 32'hBAD0BAD0;
    pipe3[0] <= (d3_mem_en && !d3_mem_we) ? mem3[d3_mem_addr] : 32'hBAD3BAD3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign d1_mem_rdata = pipe1;
  assign d3_mem_rdata = pipe3[2];

  always @(posedge clk) begin
    if (d1_mem_en) en1_cnt <= en1_cnt + 1;
    if (rst1_n && d1_req_ready && req_valid) acc1_cnt <= acc1_cnt + 1;
    if ((d1_mem_we && !d1_mem_en) || (d3_mem_we && !d3_mem_en)) we_viol <= we_viol + 1;
  end

  typedef struct {
    logic        we;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        err;
    logic [31:0] data;
    logic [7:0]  addr;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_sel = sel; pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " mem_en"},    32'(o_mem_en),    32'd0);
    check({tag, " mem_we"},    32'(o_mem_we),    32'd0);
    check({tag, " mem_addr"},  32'(o_mem_addr),  32'd0);
    check({tag, " mem_wdata"}, o_mem_wdata,      32'd0);
    check({tag, " rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    check({tag, " rsp_we"},    32'(o_rsp_we),    32'd0);
    check({tag, " rsp_rd"},    32'(o_rsp_rd),    32'd0);
    check({tag, " rsp_data"},  o_rsp_data,       32'd0);
    check({tag, " rsp_err"},   32'(o_rsp_err),   32'd0);
    check({tag, " busy"},      32'(o_busy),      32'd0);
    check({tag, " req_ready"}, 32'(o_req_ready), 32'd1);
  endtask

  // Called at a negedge with the selected DUT idle; rsp_ready is held high.
  task automatic run_req(input vec_t v, input string tag);
    int          lat    = 0;
    int          en_cnt = 0;
    logic [7:0]  en_addr = '0;
    logic        en_we   = 1'b0;
    req_we = v.we; req_base = v.base; req_offset = v.off;
    req_wdata = v.wdata; req_rd = v.rd; req_valid = 1'b1;
    check({tag, " req_ready"}, 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_mem_en) begin
        en_cnt++; en_addr = o_mem_addr; en_we = o_mem_we;
      end
      if (o_rsp_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " mem_en pulses"}, 32'(en_cnt), v.err ? 32'd0 : 32'd1);
    if (!v.err) begin
      check({tag, " mem_addr"}, 32'(en_addr), 32'(v.addr));
      check({tag, " mem_we"},   32'(en_we),   32'(v.we));
    end
    check({tag, " rsp_data"}, o_rsp_data,       v.data);
    check({tag, " rsp_err"},  32'(o_rsp_err),   32'(v.err));
    check({tag, " rsp_we"},   32'(o_rsp_we),    32'(v.we));
    check({tag, " rsp_rd"},   32'(o_rsp_rd),    32'(v.rd));
    @(posedge clk);
    @(negedge clk);
    check({tag, " rsp_valid drop"}, 32'(o_rsp_valid), 32'd0);
    check({tag, " req_ready back"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_data;
    int          got, seen, en0, acc0;
    logic [31:0] b2b_wd [4];

    vecs[0] = '{1'b0, 32'h0000_0003, 16'h0002, 32'h0, 5'd7,  1'b0, 32'hDEAD_BEEF, 8'h05, 3};
    vecs[1] = '{1'b1, 32'h0000_0105, 16'hFF00, 32'h1234_5678, 5'd3, 1'b0, 32'h0, 8'h05, 2};
    vecs[2] = '{1'b0, 32'h0000_0000, 16'hFFFF, 32'h0, 5'd1,  1'b1, 32'h0, 8'h00, 1};
    vecs[3] = '{1'b1, 32'h0000_00FF, 16'h0001, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'h0, 8'h00, 1};
    vecs[4] = '{1'b0, 32'h0000_0105, 16'hFF00, 32'h0, 5'd9,  1'b0, 32'h1234_5678, 8'h05, 3};
    vecs[5] = '{1'b0, 32'h8000_0000, 16'h0000, 32'h0, 5'd11, 1'b1, 32'h0, 8'h00, 1};
    vecs[6] = '{1'b0, 32'hFFFF_FF00, 16'h0100, 32'h0, 5'd12, 1'b0, 32'h1111_2222, 8'h00, 3};
    vecs[7] = '{1'b0, 32'h0000_00FF, 16'h0000, 32'h0, 5'd31, 1'b0, 32'hCAFE_F00D, 8'hFF, 3};

    rst1_n = 1'b0; rst3_n = 1'b0; sel3 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_base = '0; req_offset = '0;
    req_wdata = '0; req_rd = '0; rsp_ready = 1'b1;
    pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;

    preload(1'b0, 8'd5,   32'hDEAD_BEEF);
    preload(1'b0, 8'd0,   32'h1111_2222);
    preload(1'b0, 8'd255, 32'hCAFE_F00D);
    preload(1'b1, 8'd21,  32'h7700_7700);

    @(negedge clk);
    check_idle_zero("reset1");
    rst1_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold rsp_ready low for five response cycles.
    rsp_ready = 1'b0;
    req_we = 1'b0; req_base = 32'd5; req_offset = 16'd0; req_rd = 5'd4; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        got = 1;
        break;
      end
    end
    check("bp rsp seen", 32'(got), 32'd1);
    bp_data = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      check("bp rsp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp rsp_data",  o_rsp_data,       bp_data);
      check("bp rsp_rd",    32'(o_rsp_rd),    32'd4);
      check("bp req_ready", 32'(o_req_ready), 32'd0);
      check("bp busy",      32'(o_busy),      32'd1);
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp rsp_valid drop", 32'(o_rsp_valid), 32'd0);
    check("bp req_ready back", 32'(o_req_ready), 32'd1);

    // Back-to-back: req_valid stays high, alternating sw/lw at word 10.
    b2b_wd[0] = 32'hA5A5_A5A5; b2b_wd[1] = 32'h0;
    b2b_wd[2] = 32'h5A5A_5A5A; b2b_wd[3] = 32'h0;
    en0 = en1_cnt; acc0 = acc1_cnt;
    for (int k = 0; k < 4; k++) begin
      req_we = (k % 2 == 0); req_base = 32'd10; req_offset = 16'd0;
      req_wdata = b2b_wd[k]; req_rd = 5'(k + 1); req_valid = 1'b1;
      got = 0;
      for (int c = 0; c < 20; c++) begin
        if (o_req_ready) begin
          got = 1;
          break;
        end
        @(negedge clk);
      end
      check("b2b ready seen", 32'(got), 32'd1);
      check("b2b accept in idle busy", 32'(o_busy), 32'd0);
      @(posedge clk);
      got = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (o_rsp_valid) begin
          got = 1;
          break;
        end
      end
      check("b2b rsp seen", 32'(got), 32'd1);
      if (k % 2 == 1) check("b2b load data", o_rsp_data, b2b_wd[k-1]);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b accept count", 32'(acc1_cnt - acc0), 32'd4);
    check("b2b mem_en count", 32'(en1_cnt - en0), 32'd4);

    // Switch to the MEM_LAT=3 instance and reset it in the middle of a load.
    rst1_n = 1'b0; sel3 = 1'b1;
    @(negedge clk);
    check_idle_zero("reset3");
    rst3_n = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_base = 32'd21; req_offset = 16'd0; req_rd = 5'd2; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("midrst issue mem_en", 32'(o_mem_en), 32'd1);
    @(negedge clk);
    check("midrst wait busy", 32'(o_busy), 32'd1);
    #2 rst3_n = 1'b0;
    #1 check_idle_zero("midrst async");
    @(negedge clk);
    rst3_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_rsp_valid) seen++;
    end
    check("midrst no response", 32'(seen), 32'd0);

    run_req('{1'b0, 32'd21, 16'd0, 32'h0, 5'd6, 1'b0, 32'h7700_7700, 8'd21, 5}, "lat3 load");
    run_req('{1'b1, 32'd30, 16'd2, 32'h3333_4444, 5'd8, 1'b0, 32'h0, 8'd32, 2}, "lat3 store");
    run_req('{1'b0, 32'd34, 16'hFFFE, 32'h0, 5'd9, 1'b0, 32'h3333_4444, 8'd32, 5}, "lat3 reload");

    check("mem_we without mem_en", 32'(we_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
